// File: rtl/axil_cmd_master.sv
// -----------------------------------------------------------------------------
// axil_cmd_master
//
// Single-outstanding AXI4-Lite master. It turns a simple single-beat
// command/response stream into AXI4-Lite write and read transactions, and it
// keeps counters of completed writes, completed reads and error completions.
//
// Optional feature: define AXIL_CMD_TIMEOUT_EN to enable the response
// watchdog. The watchdog sets the sticky timeout_err flag after
// TIMEOUT_CYCLES clocks spent waiting on the AXI side. Without the macro,
// timeout_err is tied to 0 and TIMEOUT_CYCLES has no effect.
//
// Ports
//   axilite_clk, axilite_rstb     clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/addr/wdata/wstrb    command payload (wdata/wstrb used by writes)
//   rsp_valid/rsp_ready           response handshake
//   rsp_write/rdata/resp          response payload (rdata is 0 for writes)
//   wr_cnt, rd_cnt                completed writes/reads, wrap at 16 bits
//   err_cnt                       error completions (and timeouts), saturates
//   timeout_err                   sticky watchdog flag
//   m_axil_*                      AXI4-Lite master channels AW, W, B, AR, R
// -----------------------------------------------------------------------------
module axil_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
    input  logic        axilite_clk,
    input  logic        axilite_rstb,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,

    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt,
    output logic [15:0] err_cnt,
    output logic        timeout_err,

    output logic [31:0] m_axil_awaddr,
    output logic [2:0]  m_axil_awprot,
    output logic        m_axil_awvalid,
    input  logic        m_axil_awready,
    output logic [31:0] m_axil_wdata,
    output logic [3:0]  m_axil_wstrb,
    output logic        m_axil_wvalid,
    input  logic        m_axil_wready,
    input  logic [1:0]  m_axil_bresp,
    input  logic        m_axil_bvalid,
    output logic        m_axil_bready,
    output logic [31:0] m_axil_araddr,
    output logic [2:0]  m_axil_arprot,
    output logic        m_axil_arvalid,
    input  logic        m_axil_arready,
    input  logic [31:0] m_axil_rdata,
    input  logic [1:0]  m_axil_rresp,
    input  logic        m_axil_rvalid,
    output logic        m_axil_rready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WR_B  = 3'd2,
        ST_RD_AR = 3'd3,
        ST_RD_R  = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        aw_done_r;
    logic        w_done_r;
    logic        aw_done_nxt_s;
    logic        w_done_nxt_s;

    logic        cmd_acc_s;
    logic        b_acc_s;
    logic        r_acc_s;
    logic        rsp_acc_s;

    logic        cmd_ready_r;
    logic        awvalid_r;
    logic        wvalid_r;
    logic        arvalid_r;
    logic        rsp_valid_r;

    logic        cmd_ready_nxt_s;
    logic        awvalid_nxt_s;
    logic        wvalid_nxt_s;
    logic        arvalid_nxt_s;
    logic        rsp_valid_nxt_s;

    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        cmd_write_r;

    logic        rsp_write_r;
    logic [31:0] rsp_rdata_r;
    logic [1:0]  rsp_resp_r;

    logic [15:0] wr_cnt_r;
    logic [15:0] rd_cnt_r;
    logic [15:0] err_cnt_r;
    logic        err_inc_s;
    logic        to_hit_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc16 = 16'hFFFF;
        end else begin
            sat_inc16 = value + 16'd1;
        end
    endfunction

    // State register.
    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, handshake events, and next values of the registered
    // valid/ready outputs. Each output flop is loaded from the state being
    // entered, so the outputs are valid in the first cycle of that state.
    always_comb begin
        state_nxt_s   = state_r;
        aw_done_nxt_s = aw_done_r;
        w_done_nxt_s  = w_done_r;
        cmd_acc_s     = 1'b0;
        b_acc_s       = 1'b0;
        r_acc_s       = 1'b0;
        rsp_acc_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                aw_done_nxt_s = 1'b0;
                w_done_nxt_s  = 1'b0;
                if (cmd_valid && cmd_ready_r) begin
                    cmd_acc_s   = 1'b1;
                    state_nxt_s = cmd_write ? ST_WR : ST_RD_AR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                // AW and W complete independently; leave once both have
                // handshaken, whether in the same cycle or different ones.
                if (awvalid_r && m_axil_awready) begin
                    aw_done_nxt_s = 1'b1;
                end else begin
                    aw_done_nxt_s = aw_done_r;
                end
                if (wvalid_r && m_axil_wready) begin
                    w_done_nxt_s = 1'b1;
                end else begin
                    w_done_nxt_s = w_done_r;
                end
                if (aw_done_nxt_s && w_done_nxt_s) begin
                    state_nxt_s = ST_WR_B;
                end else begin
                    state_nxt_s = ST_WR;
                end
            end
            ST_WR_B: begin
                if (m_axil_bvalid) begin
                    b_acc_s     = 1'b1;
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_WR_B;
                end
            end
            ST_RD_AR: begin
                if (m_axil_arready) begin
                    state_nxt_s = ST_RD_R;
                end else begin
                    state_nxt_s = ST_RD_AR;
                end
            end
            ST_RD_R: begin
                if (m_axil_rvalid) begin
                    r_acc_s     = 1'b1;
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_RD_R;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_acc_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
        awvalid_nxt_s   = (state_nxt_s == ST_WR) && !aw_done_nxt_s;
        wvalid_nxt_s    = (state_nxt_s == ST_WR) && !w_done_nxt_s;
        arvalid_nxt_s   = (state_nxt_s == ST_RD_AR);
        rsp_valid_nxt_s = (state_nxt_s == ST_RSP);
        err_inc_s       = (rsp_acc_s && (rsp_resp_r != 2'b00)) || to_hit_s;
    end

    // Registered handshake outputs and the AW/W completion flags.
    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            cmd_ready_r <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
        end else begin
            cmd_ready_r <= cmd_ready_nxt_s;
            awvalid_r   <= awvalid_nxt_s;
            wvalid_r    <= wvalid_nxt_s;
            arvalid_r   <= arvalid_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            aw_done_r   <= aw_done_nxt_s;
            w_done_r    <= w_done_nxt_s;
        end
    end

    // Command payload capture; only loaded in IDLE, so the AXI payloads stay
    // constant for the whole transaction.
    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            wstrb_r     <= 4'h0;
            cmd_write_r <= 1'b0;
        end else if (cmd_acc_s) begin
            addr_r      <= cmd_addr;
            wdata_r     <= cmd_write ? cmd_wdata : 32'h0000_0000;
            wstrb_r     <= cmd_write ? cmd_wstrb : 4'h0;
            cmd_write_r <= cmd_write;
        end else begin
            addr_r      <= addr_r;
            wdata_r     <= wdata_r;
            wstrb_r     <= wstrb_r;
            cmd_write_r <= cmd_write_r;
        end
    end

    // Response capture from B or R; held until the next completion.
    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            rsp_write_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_resp_r  <= 2'b00;
        end else if (b_acc_s) begin
            rsp_write_r <= cmd_write_r;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_resp_r  <= m_axil_bresp;
        end else if (r_acc_s) begin
            rsp_write_r <= cmd_write_r;
            rsp_rdata_r <= m_axil_rdata;
            rsp_resp_r  <= m_axil_rresp;
        end else begin
            rsp_write_r <= rsp_write_r;
            rsp_rdata_r <= rsp_rdata_r;
            rsp_resp_r  <= rsp_resp_r;
        end
    end

    // Status counters, updated when the response is consumed.
    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            wr_cnt_r  <= 16'h0000;
            rd_cnt_r  <= 16'h0000;
            err_cnt_r <= 16'h0000;
        end else begin
            if (rsp_acc_s && rsp_write_r) begin
                wr_cnt_r <= wr_cnt_r + 16'd1;
            end else begin
                wr_cnt_r <= wr_cnt_r;
            end
            if (rsp_acc_s && !rsp_write_r) begin
                rd_cnt_r <= rd_cnt_r + 16'd1;
            end else begin
                rd_cnt_r <= rd_cnt_r;
            end
            if (err_inc_s) begin
                err_cnt_r <= sat_inc16(err_cnt_r);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

`ifdef AXIL_CMD_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] to_cnt_r;
    logic        to_active_s;
    logic        timeout_err_r;

    // Watchdog runs while waiting on any AXI channel; it fires once, on the
    // cycle the count reaches the limit, and then holds at the limit.
    always_comb begin
        to_active_s = 1'b0;
        case (state_r)
            ST_WR, ST_WR_B, ST_RD_AR, ST_RD_R: to_active_s = 1'b1;
            default:                           to_active_s = 1'b0;
        endcase
        to_hit_s = to_active_s && (to_cnt_r == (TO_LIMIT - 16'd1));
    end

    // Watchdog counter and sticky flag; the counter clears on entry to IDLE.
    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            to_cnt_r      <= 16'h0000;
            timeout_err_r <= 1'b0;
        end else begin
            if (state_nxt_s == ST_IDLE) begin
                to_cnt_r <= 16'h0000;
            end else if (to_active_s && (to_cnt_r != TO_LIMIT)) begin
                to_cnt_r <= to_cnt_r + 16'd1;
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            if (to_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign to_hit_s    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign cmd_ready      = cmd_ready_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_write      = rsp_write_r;
    assign rsp_rdata      = rsp_rdata_r;
    assign rsp_resp       = rsp_resp_r;
    assign wr_cnt         = wr_cnt_r;
    assign rd_cnt         = rd_cnt_r;
    assign err_cnt        = err_cnt_r;

    assign m_axil_awaddr  = addr_r;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_r;
    assign m_axil_wdata   = wdata_r;
    assign m_axil_wstrb   = wstrb_r;
    assign m_axil_wvalid  = wvalid_r;
    assign m_axil_araddr  = addr_r;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_r;
    // Response readies decode the state register only.
    assign m_axil_bready  = (state_r == ST_WR_B);
    assign m_axil_rready  = (state_r == ST_RD_R);

endmodule

// File: tb/tb_axil_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_axil_cmd_master
//
// Directed bench for axil_cmd_master with a behavioural AXI4-Lite slave that
// has per-channel wait-state knobs, a small memory, and a decode-error region
// at addresses with bit 31 set. Expected responses are pushed to a queue when
// a command is issued and popped when the DUT presents a response.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axil_cmd_master;

    logic        clk;
    logic        rstb;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [15:0] err_cnt;
    logic        timeout_err;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    axil_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .axilite_clk    (clk),
        .axilite_rstb   (rstb),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wstrb      (cmd_wstrb),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_write      (rsp_write),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .wr_cnt         (wr_cnt),
        .rd_cnt         (rd_cnt),
        .err_cnt        (err_cnt),
        .timeout_err    (timeout_err),
        .m_axil_awaddr  (awaddr),
        .m_axil_awprot  (awprot),
        .m_axil_awvalid (awvalid),
        .m_axil_awready (awready),
        .m_axil_wdata   (wdata),
        .m_axil_wstrb   (wstrb),
        .m_axil_wvalid  (wvalid),
        .m_axil_wready  (wready),
        .m_axil_bresp   (bresp),
        .m_axil_bvalid  (bvalid),
        .m_axil_bready  (bready),
        .m_axil_araddr  (araddr),
        .m_axil_arprot  (arprot),
        .m_axil_arvalid (arvalid),
        .m_axil_arready (arready),
        .m_axil_rdata   (rdata),
        .m_axil_rresp   (rresp),
        .m_axil_rvalid  (rvalid),
        .m_axil_rready  (rready)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors;
    int          miscompares;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;

    // Slave knobs and state
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          ar_dly;
    int          r_dly;
    int          b_count;
    logic [31:0] mem [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "time limit");
    end

    // Behavioural AXI4-Lite slave, evaluated on the falling edge so that its
    // readies/valids are stable for the next rising edge. B and R are decided
    // before AW/W/AR so a response never appears in its request's cycle.
    initial begin : slave
        logic        aw_got;
        logic        w_got;
        logic        ar_got;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [31:0] rd_addr;
        int          aw_cnt;
        int          w_cnt;
        int          b_cnt;
        int          ar_cnt;
        int          r_cnt;
        aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
        wr_addr = 32'h0; wr_data = 32'h0; rd_addr = 32'h0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                arready = 1'b0; rvalid = 1'b0;
            end else begin
                bvalid = 1'b0;
                if (aw_got && w_got) begin
                    if (b_cnt >= b_dly) begin
                        bvalid = 1'b1;
                        bresp  = wr_addr[31] ? 2'b11 : 2'b00;
                        if (bready) begin
                            if (!wr_addr[31]) mem[wr_addr] = wr_data;
                            b_count++;
                            aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
                        end
                    end else begin
                        b_cnt++;
                    end
                end
                rvalid = 1'b0;
                if (ar_got) begin
                    if (r_cnt >= r_dly) begin
                        rvalid = 1'b1;
                        rresp  = rd_addr[31] ? 2'b11 : 2'b00;
                        rdata  = mem.exists(rd_addr) ? mem[rd_addr] : 32'hDEAD_BEEF;
                        if (rready) begin
                            ar_got = 1'b0; r_cnt = 0;
                        end
                    end else begin
                        r_cnt++;
                    end
                end
                awready = 1'b0;
                if (awvalid && !aw_got) begin
                    if (aw_cnt >= aw_dly) begin
                        awready = 1'b1; aw_got = 1'b1; wr_addr = awaddr; aw_cnt = 0;
                    end else begin
                        aw_cnt++;
                    end
                end
                wready = 1'b0;
                if (wvalid && !w_got) begin
                    if (w_cnt >= w_dly) begin
                        wready = 1'b1; w_got = 1'b1; wr_data = wdata; w_cnt = 0;
                    end else begin
                        w_cnt++;
                    end
                end
                arready = 1'b0;
                if (arvalid && !ar_got) begin
                    if (ar_cnt >= ar_dly) begin
                        arready = 1'b1; ar_got = 1'b1; rd_addr = araddr; ar_cnt = 0;
                    end else begin
                        ar_cnt++;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".wr_cnt"},  {16'h0, wr_cnt},  32'(exp_wr));
        check({tag, ".rd_cnt"},  {16'h0, rd_cnt},  32'(exp_rd));
        check({tag, ".err_cnt"}, {16'h0, err_cnt}, 32'(exp_err));
    endtask

    // Call at a falling edge. Returns at the falling edge after acceptance.
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
        exp_t e;
        int   n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = 4'hF;
        e.wr    = wr;
        e.rdata = exp_rdata;
        e.resp  = exp_resp;
        sb_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
    endtask

    // Wait for a response, optionally stall rsp_ready, then consume it and
    // compare against the scoreboard head.
    task automatic get_rsp(input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_wait", {31'h0, rsp_valid}, 32'h1);
        check("sb_nonempty", {31'h0, (sb_q.size() != 0)}, 32'h1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            check("hold.rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("hold.rsp_rdata", rsp_rdata, e.rdata);
            check("hold.cmd_ready", {31'h0, cmd_ready}, 32'h0);
            check("hold.axi_valids", {29'h0, awvalid, wvalid, arvalid}, 32'h0);
            @(negedge clk);
        end
        check("rsp_write", {31'h0, rsp_write}, {31'h0, e.wr});
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_resp",  {30'h0, rsp_resp}, {30'h0, e.resp});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("cmd_ready_after_rsp", {31'h0, cmd_ready}, 32'h1);
        check("rsp_valid_dropped", {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; b_count = 0;
        rstb = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst.valids", {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
        check("rst.rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata[27:0]}, 32'h0);
        check("rst.timeout_err", {31'h0, timeout_err}, 32'h0);
        check_counters("rst");
        rstb = 1'b1;
        @(negedge clk);
        check("idle.cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // Zero-wait write: AW/W at N+1, B at N+2, response at N+3
        send_cmd(1'b1, 32'h0010_0000, 32'h0000_0040, 32'h0, 2'b00);
        check("wr.awvalid_n1", {30'h0, awvalid, wvalid}, 32'h3);
        check("wr.awaddr", awaddr, 32'h0010_0000);
        check("wr.wdata", wdata, 32'h0000_0040);
        check("wr.wstrb_prot", {25'h0, awprot, wstrb}, 32'h0000_000F);
        @(negedge clk);
        check("wr.n2", {29'h0, awvalid, wvalid, bready}, 32'h1);
        check("wr.n2_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        check("wr.n3_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        get_rsp(0);
        exp_wr++;
        check_counters("wr1");

        // Zero-wait read back
        send_cmd(1'b0, 32'h0010_0000, 32'h0, 32'h0000_0040, 2'b00);
        check("rd.arvalid_n1", {31'h0, arvalid}, 32'h1);
        check("rd.araddr", {araddr[31:3], arprot}, {29'h0002_0000, 3'b000});
        @(negedge clk);
        check("rd.n2_rready", {30'h0, arvalid, rready}, 32'h1);
        @(negedge clk);
        check("rd.n3_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        get_rsp(0);
        exp_rd++;
        check_counters("rd1");

        // W delayed 3 clocks behind AW: awvalid drops, wvalid/wdata hold
        w_dly = 3;
        send_cmd(1'b1, 32'h0010_0004, 32'h0000_0030, 32'h0, 2'b00);
        check("wdly.n1", {30'h0, awvalid, wvalid}, 32'h3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wdly.valids", {30'h0, awvalid, wvalid}, 32'h1);
            check("wdly.wdata", wdata, 32'h0000_0030);
        end
        @(negedge clk);
        check("wdly.done", {29'h0, awvalid, wvalid, bready}, 32'h1);
        get_rsp(0);
        w_dly = 0;
        exp_wr++;
        check_counters("wdly");
        check("wdly.b_count", 32'(b_count), 32'd2);

        // Decode error on write
        send_cmd(1'b1, 32'h8100_0000, 32'h0000_00AA, 32'h0, 2'b11);
        get_rsp(0);
        exp_wr++; exp_err++;
        check_counters("decerr");

        // Response stalled 5 clocks
        send_cmd(1'b0, 32'h0010_0004, 32'h0, 32'h0000_0030, 2'b00);
        get_rsp(5);
        exp_rd++;
        check_counters("stall");

        // Asynchronous reset while waiting in WR_B
        b_dly = 10;
        send_cmd(1'b1, 32'h0010_0008, 32'h0000_0055, 32'h0, 2'b00);
        @(negedge clk);
        check("wrb.bready", {31'h0, bready}, 32'h1);
        #2;
        rstb = 1'b0;
        #1;
        check("arst.outs", {26'h0, cmd_ready, awvalid, wvalid, arvalid, bready, rsp_valid}, 32'h0);
        check("arst.rsp", {30'h0, rsp_resp}, 32'h0);
        sb_q.delete();
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        check_counters("arst");
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        b_dly = 0;
        @(negedge clk);
        send_cmd(1'b1, 32'h0010_000C, 32'h0000_0077, 32'h0, 2'b00);
        get_rsp(0);
        exp_wr++;
        send_cmd(1'b0, 32'h0010_000C, 32'h0, 32'h0000_0077, 2'b00);
        get_rsp(0);
        exp_rd++;
        check_counters("post_rst");

`ifdef AXIL_CMD_TIMEOUT_EN
        // B withheld 40 clocks: watchdog fires once, late B still accepted
        b_dly = 40;
        send_cmd(1'b1, 32'h0010_0010, 32'h0000_0099, 32'h0, 2'b00);
        check("to.before", {31'h0, timeout_err}, 32'h0);
        repeat (20) @(negedge clk);
        check("to.flag", {31'h0, timeout_err}, 32'h1);
        check("to.bready", {31'h0, bready}, 32'h1);
        exp_err++;
        check_counters("to.mid");
        get_rsp(0);
        b_dly = 0;
        exp_wr++;
        check_counters("to.end");
        check("to.sticky", {31'h0, timeout_err}, 32'h1);
`else
        check("timeout_err_tied", {31'h0, timeout_err}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
